// File: rtl/layer_bias_sequencer.sv
// Sequences N_GROUPS constant bias banks into an adder tree, one group per handshake.
// Optional macro BIAS_SEQ_BYPASS_EN adds a bias_bypass input that forces zero biases.
module layer_bias_sequencer #(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 4,
  parameter int GW           = $clog2(N_GROUPS)
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef BIAS_SEQ_BYPASS_EN
  input  logic                                bias_bypass,
`endif
  input  logic                                start,
  input  logic [N_GROUPS*N_adder_tree*18-1:0] bias_bank_in,
  input  logic                                acc_ready,
  input  logic                                grp_done,
  output logic [N_adder_tree*18-1:0]          bias_q,
  output logic                                bias_valid,
  output logic [GW-1:0]                       group_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int            LW   = N_adder_tree * 18;
  localparam logic [GW-1:0] LAST = GW'(N_GROUPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESENT,
    WAIT_ACC,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   group_idx_q, group_idx_d;
  logic            busy_q, busy_d;
  logic [LW-1:0]   bias_d;
  logic [LW-1:0]   bank_sel;
  logic            zero_bias;

`ifdef BIAS_SEQ_BYPASS_EN
  assign zero_bias = bias_bypass;
`else
  assign zero_bias = 1'b0;
`endif

  // Compare-and-select keeps every bank slice a constant part-select.
  always_comb begin
    bank_sel = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (group_idx_q == GW'(g)) begin
        bank_sel = bias_bank_in[g*LW +: LW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    group_idx_d = group_idx_q;
    busy_d      = busy_q;
    bias_d      = bias_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          group_idx_d = '0;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        bias_d  = zero_bias ? '0 : bank_sel;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (acc_ready) begin
          state_d = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        if (grp_done) begin
          if (group_idx_q == LAST) begin
            state_d = FINISH;
          end else begin
            group_idx_d = group_idx_q + GW'(1);
            state_d     = LOAD;
          end
        end
      end
      FINISH: begin
        busy_d      = 1'b0;
        group_idx_d = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      group_idx_q <= '0;
      busy_q      <= 1'b0;
      bias_q      <= '0;
    end else begin
      state_q     <= state_d;
      group_idx_q <= group_idx_d;
      busy_q      <= busy_d;
      bias_q      <= bias_d;
    end
  end

  // All outputs decode directly from flops so reset clears them immediately.
  assign bias_valid = (state_q == PRESENT);
  assign done       = (state_q == FINISH);
  assign group_idx  = group_idx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_layer_bias_sequencer.sv
// Randomized scoreboard bench for layer_bias_sequencer: expected transfers are queued
// when a pass starts and a negedge monitor pops them on every bias_valid/acc_ready handshake.
module tb_layer_bias_sequencer;

  localparam int NA = 16;
  localparam int NG = 4;
  localparam int GW = 2;
  localparam int LW = NA * 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NG*LW-1:0]  bias_bank_in;
  logic              acc_ready;
  logic              grp_done;
  logic [LW-1:0]     bias_q;
  logic              bias_valid;
  logic [GW-1:0]     group_idx;
  logic              busy;
  logic              done;
`ifdef BIAS_SEQ_BYPASS_EN
  logic              bias_bypass;
`endif

  layer_bias_sequencer #(
    .N_adder_tree(NA),
    .N_GROUPS    (NG),
    .GW          (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef BIAS_SEQ_BYPASS_EN
    .bias_bypass (bias_bypass),
`endif
    .start       (start),
    .bias_bank_in(bias_bank_in),
    .acc_ready   (acc_ready),
    .grp_done    (grp_done),
    .bias_q      (bias_q),
    .bias_valid  (bias_valid),
    .group_idx   (group_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [17:0]   lanes [NG][NA];
  logic [LW-1:0] expBias [$];
  int            expIdx [$];
  int            checks = 0;
  int            fails = 0;
  int            doneCount = 0;
  bit            bypassOn = 1'b0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] bankVector(input int g);
    logic [LW-1:0] v;
    v = '0;
    for (int l = 0; l < NA; l++) v[l*18 +: 18] = lanes[g][l];
    return v;
  endfunction

  task automatic loadBanks();
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < NA; l++)
        lanes[g][l] = 18'($urandom);
    lanes[3][0] = 18'h3E884;
    for (int g = 0; g < NG; g++) bias_bank_in[g*LW +: LW] = bankVector(g);
  endtask

  task automatic queueExpected();
    for (int g = 0; g < NG; g++) begin
      expBias.push_back(bypassOn ? '0 : bankVector(g));
      expIdx.push_back(g);
    end
  endtask

  // Monitor: every handshake pops the next expected group; a held vector must not move.
  logic          prevHold = 1'b0;
  logic [LW-1:0] prevBias;
  logic [GW-1:0] prevIdx;
  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      if (bias_valid && prevHold) begin
        checkOutput("hold_bias", bias_q, prevBias);
        checkOutput("hold_idx", LW'(group_idx), LW'(prevIdx));
      end
      if (bias_valid && acc_ready) begin
        if (expBias.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_xfer: got group %0d expected no transfer", group_idx);
        end else begin
          logic [LW-1:0] eb;
          int ei;
          eb = expBias.pop_front();
          ei = expIdx.pop_front();
          checkOutput("xfer_bias", bias_q, eb);
          checkOutput("xfer_idx", LW'(group_idx), LW'(ei));
          if (ei == 3 && !bypassOn) checkOutput("lane0_sign", LW'(bias_q[17:0]), LW'(18'h3E884));
        end
      end
      if (done) doneCount++;
      prevHold = bias_valid && !acc_ready;
      prevBias = bias_q;
      prevIdx  = group_idx;
    end
  end

  // One layer pass. pct/holdFirst shape acc_ready, gdDelay spaces grp_done after each
  // transfer, spurious injects ignored start/grp_done pulses.
  task automatic applyStimulus(input int pct, input int holdFirst, input int gdDelay,
                               input bit spurious, input bit startAtDone, output int cycles);
    bit prevValid, prevAcc, armed, ok, xfer;
    int left, validRun, dc0;
    prevValid = 0; prevAcc = 0; armed = 0; ok = 0; left = 0; validRun = 0;
    dc0 = doneCount;
    @(posedge clk); #1;
    start = 1'b1; acc_ready = 1'b0; grp_done = 1'b0;
    queueExpected();
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    checkOutput("busy_after_start", LW'(busy), LW'(1));
    checkOutput("idx_after_start", LW'(group_idx), LW'(0));
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        ok = 1;
        break;
      end
      xfer = prevValid && prevAcc;
      grp_done = 1'b0;
      start = 1'b0;
      if (xfer) begin
        armed = 1;
        left = gdDelay;
      end
      if (armed) begin
        if (left == 0) begin
          grp_done = 1'b1;
          armed = 0;
        end else begin
          left--;
        end
      end
      if (bias_valid) begin
        validRun++;
        acc_ready = (validRun > holdFirst) && ($urandom_range(0, 99) < pct);
      end else begin
        validRun = 0;
        acc_ready = 1'($urandom);
      end
      if (spurious && bias_valid && !armed && !grp_done && $urandom_range(0, 1) == 1) grp_done = 1'b1;
      if (spurious && busy && $urandom_range(0, 2) == 0) start = 1'b1;
      prevValid = bias_valid;
      prevAcc = acc_ready;
      @(posedge clk); #1;
      cycles++;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL pass_timeout: got no done after %0d cycles expected done", cycles);
    end
    acc_ready = 1'b0;
    grp_done = 1'b0;
    start = startAtDone;
    checkOutput("all_groups_sent", LW'(expBias.size()), LW'(0));
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("done_one_cycle", LW'(done), LW'(0));
    checkOutput("busy_cleared", LW'(busy), LW'(0));
    checkOutput("idx_wrapped", LW'(group_idx), LW'(0));
    checkOutput("done_pulses", LW'(doneCount - dc0), LW'(1));
    @(posedge clk); #1;
    checkOutput("idle_after_pass", LW'(busy), LW'(0));
    expBias.delete();
    expIdx.delete();
  endtask

  task automatic resetMidPass();
    int dc0, cyc;
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; acc_ready = 1'b0; grp_done = 1'b0;
    queueExpected();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bias_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("reached_present", LW'(seen), LW'(1));
    dc0 = doneCount;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_bias_q", bias_q, '0);
    checkOutput("rst_bias_valid", LW'(bias_valid), LW'(0));
    checkOutput("rst_group_idx", LW'(group_idx), LW'(0));
    checkOutput("rst_busy", LW'(busy), LW'(0));
    checkOutput("rst_done", LW'(done), LW'(0));
    expBias.delete();
    expIdx.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("idle_after_rst", LW'(busy | bias_valid | done), LW'(0));
    end
    checkOutput("no_done_on_abort", LW'(doneCount - dc0), LW'(0));
    applyStimulus(100, 0, 0, 0, 0, cyc);
    checkOutput("post_rst_cycles", LW'(cyc), LW'(12));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; acc_ready = 1'b0; grp_done = 1'b0;
`ifdef BIAS_SEQ_BYPASS_EN
    bias_bypass = 1'b0;
`endif
    loadBanks();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_bias_q", bias_q, '0);
    checkOutput("reset_flags", LW'({bias_valid, busy, done}), LW'(0));
    checkOutput("reset_group_idx", LW'(group_idx), LW'(0));
    rst = 1'b0;

    applyStimulus(100, 0, 0, 0, 0, cyc);
    checkOutput("full_pass_cycles", LW'(cyc), LW'(12));

    applyStimulus(100, 5, 0, 0, 0, cyc);
    checkOutput("backpressure_cycles", LW'(cyc), LW'(32));

    resetMidPass();

    for (int k = 0; k < 5; k++) begin
      loadBanks();
      applyStimulus($urandom_range(30, 100), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, k == 1, cyc);
    end

`ifdef BIAS_SEQ_BYPASS_EN
    bypassOn = 1'b1;
    bias_bypass = 1'b1;
    applyStimulus(100, 0, 0, 0, 0, cyc);
    checkOutput("bypass_cycles", LW'(cyc), LW'(12));
    bypassOn = 1'b0;
    bias_bypass = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
